// File: rtl/ddr_phy_train_pkg.sv
// Shared types, constants and helpers for the DDR4 RX lane read-capture trainer.
// Holds the trainer state encoding, TRAIN_ERR codes and the pattern-rotation match.
package ddr_phy_train_pkg;

   localparam logic [3:0]  PATTERN    = 4'b0011;
   localparam int unsigned TAP_W      = 7;
   localparam int unsigned MAX_TAPS   = 128;
   localparam int unsigned SETTLE_CYC = 8;
   localparam int unsigned CHECK_CYC  = 16;
   localparam int unsigned MIN_EYE    = 4;
   localparam int unsigned MAX_SLIPS  = 3;

   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(MAX_TAPS - 1);
   localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);

   localparam logic [1:0] ERR_OK     = 2'd0;
   localparam logic [1:0] ERR_NO_EYE = 2'd1;
   localparam logic [1:0] ERR_NARROW = 2'd2;
   localparam logic [1:0] ERR_ALIGN  = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_LOAD      = 4'd1,
      S_SETTLE    = 4'd2,
      S_CHECK     = 4'd3,
      S_STEP      = 4'd4,
      S_CENTER    = 4'd5,
      S_SLIP      = 4'd6,
      S_SLIP_WAIT = 4'd7,
      S_DONE      = 4'd8,
      S_ERROR     = 4'd9
   } train_state_t;

   // True when the nibble is any of the four rotations of the training pattern.
   function automatic logic is_rotation(input logic [3:0] d);
      logic [3:0] rot;
      logic       hit;
      rot = PATTERN;
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         hit = hit | (d == rot);
         rot = {rot[2:0], rot[3]};
      end
      return hit;
   endfunction

endpackage

// File: rtl/ddr4_rx_lane_trainer_if.sv
// Control and IOD-facing signal bundle of the RX lane trainer.
// master = trainer side, slave = IOD / read-datapath / controller side.
interface ddr4_rx_lane_trainer_if;
   import ddr_phy_train_pkg::*;

   logic             TRAIN_START;
   logic [3:0]       RX_DATA_0;
   logic             DELAY_LINE_OUT_OF_RANGE_0;
   logic             DELAY_LINE_MOVE_0;
   logic             DELAY_LINE_DIRECTION_0;
   logic             DELAY_LINE_LOAD_0;
   logic             RX_BIT_SLIP_0;
   logic [3:0]       RX_DATA_OUT;
   logic             RX_VALID;
   logic             TRAIN_BUSY;
   logic             TRAIN_DONE;
   logic [1:0]       TRAIN_ERR;
   logic [TAP_W-1:0] TAP_VAL;
   logic [TAP_W-1:0] EYE_FIRST;
   logic [TAP_W-1:0] EYE_LAST;

   modport master (
      input  TRAIN_START, RX_DATA_0, DELAY_LINE_OUT_OF_RANGE_0,
      output DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0, RX_BIT_SLIP_0,
      output RX_DATA_OUT, RX_VALID, TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR,
      output TAP_VAL, EYE_FIRST, EYE_LAST
   );

   modport slave (
      output TRAIN_START, RX_DATA_0, DELAY_LINE_OUT_OF_RANGE_0,
      input  DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0, RX_BIT_SLIP_0,
      input  RX_DATA_OUT, RX_VALID, TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR,
      input  TAP_VAL, EYE_FIRST, EYE_LAST
   );
endinterface

// File: rtl/ddr_rx_sample_checker.sv
// Per-tap stability check: CHECK_CYC consecutive samples must equal the first one,
// and that first sample must be a rotation of the training pattern.
module ddr_rx_sample_checker
   import ddr_phy_train_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic [3:0] i_data,
   output logic       o_done,
   output logic       o_pass
);
   localparam logic [3:0] CHK_LAST = 4'(CHECK_CYC - 1);

   logic [3:0] r_cnt;
   logic [3:0] r_first;
   logic       r_stable;
   logic [3:0] w_ref;
   logic       w_stable;

   // Reference sample and running stability for the current window.
   always_comb begin
      w_ref    = r_first;
      w_stable = r_stable;
      if (r_cnt == 4'd0) begin
         w_ref    = i_data;
         w_stable = 1'b1;
      end else begin
         w_stable = r_stable & (i_data == r_first);
      end
      o_done = i_en & (r_cnt == CHK_LAST);
      o_pass = o_done & w_stable & is_rotation(w_ref);
   end

   // Sample counter and captured reference; re-arms whenever disabled or complete.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= 4'd0;
         r_first  <= 4'd0;
         r_stable <= 1'b0;
      end else if (!i_en || o_done) begin
         r_cnt    <= 4'd0;
         r_first  <= r_first;
         r_stable <= 1'b0;
      end else begin
         r_cnt    <= r_cnt + 4'd1;
         r_first  <= w_ref;
         r_stable <= w_stable;
      end
   end
endmodule

// File: rtl/ddr4_rx_lane_trainer.sv
// Read-capture trainer for one DDR4 DQ lane: sweeps the IOD delay line, centres in
// the data eye, then bit-slips until the deserialized nibble equals PATTERN.
module ddr4_rx_lane_trainer
   import ddr_phy_train_pkg::*;
(
   input  logic                   FAB_CLK,
   input  logic                   ARST_N,
   ddr4_rx_lane_trainer_if.master bus
);
   train_state_t     r_state, w_state;
   logic [3:0]       r_cnt, w_cnt;
   logic [TAP_W-1:0] r_tap, w_tap, r_first, w_first, r_last, w_last;
   logic             r_found, w_found, r_align, w_align, r_phase, w_phase;
   logic [1:0]       r_slips, w_slips, r_err, w_err;
   logic             r_move, w_move, r_dir, w_dir, r_load, w_load, r_slip, w_slip;
   logic [3:0]       r_data_out;
   logic             r_valid, r_busy, r_done;
   logic             w_chk_en, w_chk_done, w_chk_pass;
   logic [TAP_W:0]   w_width;
   logic [TAP_W-1:0] w_target;

   localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [TAP_W:0] MIN_EYE_W   = (TAP_W + 1)'(MIN_EYE);
   localparam logic [1:0]     MAX_SLIPS_W = 2'(MAX_SLIPS);

   ddr_rx_sample_checker u_checker (
      .i_clk   (FAB_CLK),
      .i_rst_n (ARST_N),
      .i_en    (w_chk_en),
      .i_data  (bus.RX_DATA_0),
      .o_done  (w_chk_done),
      .o_pass  (w_chk_pass)
   );

   assign w_width  = {1'b0, r_last} - {1'b0, r_first} + {{TAP_W{1'b0}}, 1'b1};
   assign w_target = r_first + w_width[TAP_W:1];

   // Next-state and next-register decode; pulses are decided here and registered.
   always_comb begin
      w_state = r_state;  w_cnt   = r_cnt;   w_tap   = r_tap;
      w_first = r_first;  w_last  = r_last;  w_found = r_found;
      w_align = r_align;  w_slips = r_slips; w_phase = r_phase;
      w_err   = r_err;    w_dir   = r_dir;
      w_move  = 1'b0;     w_load  = 1'b0;    w_slip  = 1'b0;
      w_chk_en = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (bus.TRAIN_START) begin
               w_state = S_LOAD;
               w_load  = 1'b1;
               w_tap   = {TAP_W{1'b0}};
               w_err   = ERR_OK;
               w_first = {TAP_W{1'b0}};
               w_last  = {TAP_W{1'b0}};
               w_found = 1'b0;
               w_align = 1'b0;
               w_slips = 2'd0;
               w_cnt   = 4'd0;
            end else begin
               w_state = r_state;
            end
         end
         S_LOAD: begin
            w_cnt   = 4'd0;
            w_state = S_SETTLE;
         end
         S_SETTLE, S_SLIP_WAIT: begin
            if (r_cnt == SETTLE_LAST) begin
               w_cnt = 4'd0;
               // After centring, settling leads to slip alignment instead of another check.
               if ((r_state == S_SLIP_WAIT) || r_align) begin
                  w_state = S_SLIP;
               end else begin
                  w_state = S_CHECK;
               end
            end else begin
               w_cnt = r_cnt + 4'd1;
            end
         end
         S_CHECK: begin
            w_chk_en = 1'b1;
            if (w_chk_done && w_chk_pass) begin
               if (!r_found) begin
                  w_first = r_tap;
                  w_found = 1'b1;
               end else begin
                  w_first = r_first;
               end
               w_last  = r_tap;
               w_state = S_STEP;
            end else if (w_chk_done && r_found) begin
               w_state = S_CENTER;
               w_phase = 1'b0;
               w_dir   = 1'b0;
            end else if (w_chk_done) begin
               w_state = S_STEP;
            end else begin
               w_state = S_CHECK;
            end
         end
         S_STEP: begin
            if ((r_tap == TAP_LAST) || bus.DELAY_LINE_OUT_OF_RANGE_0) begin
               if (r_found) begin
                  w_state = S_CENTER;
                  w_phase = 1'b0;
                  w_dir   = 1'b0;
               end else begin
                  w_state = S_ERROR;
                  w_err   = ERR_NO_EYE;
               end
            end else begin
               w_move  = 1'b1;
               w_dir   = 1'b1;
               w_tap   = r_tap + TAP_ONE;
               w_cnt   = 4'd0;
               w_state = S_SETTLE;
            end
         end
         S_CENTER: begin
            w_dir = 1'b0;
            if (w_width < MIN_EYE_W) begin
               w_state = S_ERROR;
               w_err   = ERR_NARROW;
            end else if (bus.DELAY_LINE_OUT_OF_RANGE_0) begin
               w_state = S_ERROR;
               w_err   = ERR_NO_EYE;
            end else if (r_tap > w_target) begin
               // Alternate phases keep decrement pulses off consecutive cycles.
               if (!r_phase) begin
                  w_move = 1'b1;
                  w_tap  = r_tap - TAP_ONE;
               end else begin
                  w_move = 1'b0;
               end
               w_phase = ~r_phase;
            end else begin
               w_slips = 2'd0;
               w_align = 1'b1;
               w_cnt   = 4'd0;
               w_state = S_SETTLE;
            end
         end
         S_SLIP: begin
            if (bus.RX_DATA_0 == PATTERN) begin
               w_state = S_DONE;
            end else if (r_slips == MAX_SLIPS_W) begin
               w_state = S_ERROR;
               w_err   = ERR_ALIGN;
            end else begin
               w_slip  = 1'b1;
               w_slips = r_slips + 2'd1;
               w_cnt   = 4'd0;
               w_state = S_SLIP_WAIT;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         r_state <= S_IDLE;  r_cnt   <= 4'd0;
         r_tap   <= {TAP_W{1'b0}}; r_first <= {TAP_W{1'b0}}; r_last <= {TAP_W{1'b0}};
         r_found <= 1'b0;    r_align <= 1'b0;  r_phase <= 1'b0;
         r_slips <= 2'd0;    r_err   <= 2'd0;
         r_move  <= 1'b0;    r_dir   <= 1'b0;  r_load  <= 1'b0;  r_slip <= 1'b0;
         r_data_out <= 4'd0; r_valid <= 1'b0;  r_busy  <= 1'b0;  r_done <= 1'b0;
      end else begin
         r_state <= w_state; r_cnt   <= w_cnt;
         r_tap   <= w_tap;   r_first <= w_first; r_last <= w_last;
         r_found <= w_found; r_align <= w_align; r_phase <= w_phase;
         r_slips <= w_slips; r_err   <= w_err;
         r_move  <= w_move;  r_dir   <= w_dir;   r_load  <= w_load;  r_slip <= w_slip;
         r_data_out <= (w_state == S_DONE) ? bus.RX_DATA_0 : r_data_out;
         r_valid <= (w_state == S_DONE);
         r_done  <= (w_state == S_DONE);
         r_busy  <= !((w_state == S_IDLE) || (w_state == S_DONE) || (w_state == S_ERROR));
      end
   end

   assign bus.DELAY_LINE_MOVE_0      = r_move;
   assign bus.DELAY_LINE_DIRECTION_0 = r_dir;
   assign bus.DELAY_LINE_LOAD_0      = r_load;
   assign bus.RX_BIT_SLIP_0          = r_slip;
   assign bus.RX_DATA_OUT            = r_data_out;
   assign bus.RX_VALID               = r_valid;
   assign bus.TRAIN_BUSY             = r_busy;
   assign bus.TRAIN_DONE             = r_done;
   assign bus.TRAIN_ERR              = r_err;
   assign bus.TAP_VAL                = r_tap;
   assign bus.EYE_FIRST              = r_first;
   assign bus.EYE_LAST               = r_last;
endmodule

// File: tb/tb_ddr4_rx_lane_trainer.sv
// Bench for ddr4_rx_lane_trainer: behavioural IOD (pass window + rotation offset)
// drives the lane; expected training results are derived from the window geometry.
module tb_ddr4_rx_lane_trainer;
   localparam logic [3:0] PAT = 4'b0011;

   logic FAB_CLK = 1'b0;
   logic ARST_N;
   ddr4_rx_lane_trainer_if bus();

   ddr4_rx_lane_trainer dut (
      .FAB_CLK (FAB_CLK),
      .ARST_N  (ARST_N),
      .bus     (bus)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // IOD model configuration (written only by the stimulus process)
   int win_lo = -1, win_hi = -2, m_offset = 0;
   bit m_never = 1'b0, m_oor = 1'b0;

   // IOD model state and cumulative pulse counters (written only by the monitor)
   int m_tap = 0, m_slips = 0;
   int tot_inc = 0, tot_dec = 0, tot_slip = 0, tot_load = 0, tot_viol = 0;
   logic [2:0] prev_pulse = 3'b000;

   function automatic logic [3:0] rotl(input logic [3:0] v, input int k);
      logic [3:0] r;
      r = v;
      for (int i = 0; i < k; i++) r = {r[2:0], r[3]};
      return r;
   endfunction

   // IOD reaction to trainer pulses, plus pulse-spacing monitor
   always @(posedge FAB_CLK) begin
      logic [2:0] cur;
      cur = {bus.DELAY_LINE_MOVE_0, bus.DELAY_LINE_LOAD_0, bus.RX_BIT_SLIP_0};
      if (bus.DELAY_LINE_LOAD_0) begin
         m_tap   <= 0;
         m_slips <= 0;
         tot_load <= tot_load + 1;
      end else if (bus.DELAY_LINE_MOVE_0 && bus.DELAY_LINE_DIRECTION_0) begin
         m_tap   <= m_tap + 1;
         tot_inc <= tot_inc + 1;
      end else if (bus.DELAY_LINE_MOVE_0) begin
         m_tap   <= m_tap - 1;
         tot_dec <= tot_dec + 1;
      end
      if (bus.RX_BIT_SLIP_0) begin
         m_slips  <= m_slips + 1;
         tot_slip <= tot_slip + 1;
      end
      if (($countones(cur) > 1) || ((cur != 3'b000) && (prev_pulse != 3'b000)))
         tot_viol <= tot_viol + 1;
      prev_pulse <= cur;
   end

   // IOD output: stable rotated pattern inside the window, noise outside
   always @(negedge FAB_CLK) begin
      if (m_tap >= win_lo && m_tap <= win_hi)
         bus.RX_DATA_0 <= m_never ? rotl(PAT, 1) : rotl(PAT, (m_offset + m_slips) % 4);
      else
         bus.RX_DATA_0 <= 4'($urandom_range(0, 15));
      bus.DELAY_LINE_OUT_OF_RANGE_0 <= m_oor && (m_tap == 127);
   end

   task automatic run_case(input string name, input int lo, input int hi, input int off,
                           input bit never, input bit oor, input int poke_tap);
      int b_inc, b_dec, b_slip, b_load, b_viol, cyc;
      int exp_err, exp_tap, exp_dec, exp_slips, exp_inc, ef, el, width, target;
      bit poked;
      @(negedge FAB_CLK);
      win_lo = lo; win_hi = hi; m_offset = off; m_never = never; m_oor = oor;
      b_inc = tot_inc; b_dec = tot_dec; b_slip = tot_slip; b_load = tot_load; b_viol = tot_viol;
      bus.TRAIN_START = 1'b1;
      @(negedge FAB_CLK);
      bus.TRAIN_START = 1'b0;
      check_val({name, ":load_pulse"}, bus.DELAY_LINE_LOAD_0, 1);
      check_val({name, ":done_cleared"}, bus.TRAIN_DONE, 0);
      check_val({name, ":err_cleared"}, bus.TRAIN_ERR, 0);
      cyc = 0; poked = 1'b0;
      while (cyc < 20000 && !(bus.TRAIN_DONE || bus.TRAIN_ERR != 2'd0)) begin
         if (poke_tap >= 0 && m_tap == poke_tap && !poked) begin
            bus.TRAIN_START = 1'b1;
            poked = 1'b1;
         end else begin
            bus.TRAIN_START = 1'b0;
         end
         @(negedge FAB_CLK);
         cyc++;
      end
      bus.TRAIN_START = 1'b0;
      check_val({name, ":finished_in_budget"}, cyc < 20000, 1);

      // expected outcome from the window geometry
      exp_dec = 0; exp_slips = 0;
      if (lo < 0) begin
         exp_err = 1; ef = 0; el = 0; exp_inc = 127; exp_tap = 127;
      end else begin
         ef = lo; el = hi;
         exp_inc = (hi < 127) ? hi + 1 : 127;
         exp_tap = exp_inc;
         width = hi - lo + 1;
         if (width < 4) begin
            exp_err = 2;
         end else begin
            target  = lo + width / 2;
            exp_dec = exp_inc - target;
            exp_tap = target;
            if (never) begin
               exp_err = 3; exp_slips = 3;
            end else begin
               exp_err = 0; exp_slips = (4 - off) % 4;
            end
         end
      end
      check_val({name, ":train_err"}, bus.TRAIN_ERR, exp_err);
      check_val({name, ":train_done"}, bus.TRAIN_DONE, exp_err == 0);
      check_val({name, ":rx_valid"}, bus.RX_VALID, exp_err == 0);
      check_val({name, ":busy"}, bus.TRAIN_BUSY, 0);
      check_val({name, ":eye_first"}, bus.EYE_FIRST, ef);
      check_val({name, ":eye_last"}, bus.EYE_LAST, el);
      check_val({name, ":tap_val"}, bus.TAP_VAL, exp_tap);
      check_val({name, ":inc_moves"}, tot_inc - b_inc, exp_inc);
      check_val({name, ":dec_moves"}, tot_dec - b_dec, exp_dec);
      check_val({name, ":slips"}, tot_slip - b_slip, exp_slips);
      check_val({name, ":loads"}, tot_load - b_load, 1);
      check_val({name, ":pulse_spacing"}, tot_viol - b_viol, 0);
      if (exp_err == 0) begin
         @(negedge FAB_CLK);
         check_val({name, ":rx_data_out"}, bus.RX_DATA_OUT, PAT);
      end
   endtask

   task automatic reset_in_center();
      int b_dec, cyc, snap;
      @(negedge FAB_CLK);
      win_lo = 20; win_hi = 40; m_offset = 2; m_never = 1'b0; m_oor = 1'b0;
      b_dec = tot_dec;
      bus.TRAIN_START = 1'b1;
      @(negedge FAB_CLK);
      bus.TRAIN_START = 1'b0;
      cyc = 0;
      while (cyc < 20000 && tot_dec == b_dec) begin
         @(negedge FAB_CLK);
         cyc++;
      end
      check_val("rst_center:reached_center", cyc < 20000, 1);
      #2;
      snap = tot_inc + tot_dec + tot_slip + tot_load;
      ARST_N = 1'b0;
      #1;
      check_val("rst_center:ctrl_outputs",
                {bus.DELAY_LINE_MOVE_0, bus.DELAY_LINE_DIRECTION_0, bus.DELAY_LINE_LOAD_0,
                 bus.RX_BIT_SLIP_0, bus.RX_DATA_OUT, bus.RX_VALID, bus.TRAIN_BUSY,
                 bus.TRAIN_DONE, bus.TRAIN_ERR}, 0);
      check_val("rst_center:tap_eye_outputs", {bus.TAP_VAL, bus.EYE_FIRST, bus.EYE_LAST}, 0);
      repeat (3) @(negedge FAB_CLK);
      ARST_N = 1'b1;
      repeat (20) @(negedge FAB_CLK);
      check_val("rst_center:no_pulses_after", tot_inc + tot_dec + tot_slip + tot_load, snap);
      check_val("rst_center:idle_busy", bus.TRAIN_BUSY, 0);
      check_val("rst_center:idle_tap", bus.TAP_VAL, 0);
   endtask

   initial begin
      int lo, hi;
      ARST_N = 1'b0;
      bus.TRAIN_START = 1'b0;
      repeat (3) @(negedge FAB_CLK);
      check_val("reset:ctrl_outputs",
                {bus.DELAY_LINE_MOVE_0, bus.DELAY_LINE_DIRECTION_0, bus.DELAY_LINE_LOAD_0,
                 bus.RX_BIT_SLIP_0, bus.RX_DATA_OUT, bus.RX_VALID, bus.TRAIN_BUSY,
                 bus.TRAIN_DONE, bus.TRAIN_ERR}, 0);
      check_val("reset:tap_eye_outputs", {bus.TAP_VAL, bus.EYE_FIRST, bus.EYE_LAST}, 0);
      ARST_N = 1'b1;
      repeat (2) @(negedge FAB_CLK);

      run_case("win20_40_poke10", 20, 40, 2, 1'b0, 1'b0, 10);
      run_case("restart_from_done", 20, 40, 2, 1'b0, 1'b0, -1);
      run_case("no_eye", -1, -2, 0, 1'b0, 1'b1, -1);
      run_case("narrow50_52", 50, 52, 1, 1'b0, 1'b0, -1);
      run_case("edge100_127", 100, 127, 0, 1'b0, 1'b0, -1);
      run_case("never_align", 30, 45, 1, 1'b1, 1'b0, -1);
      for (int k = 0; k < 3; k++) begin
         lo = $urandom_range(0, 110);
         hi = lo + $urandom_range(4, 17);
         if (hi > 127) hi = 127;
         run_case($sformatf("rand%0d_%0d_%0d", k, lo, hi), lo, hi, $urandom_range(0, 3),
                  1'b0, 1'b0, -1);
      end
      reset_in_center();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
